// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop, looks the line up, answers on CR,
// streams the line on CD when needed, then commits the resulting state change.
package ace_snoop_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
  } ac_chan_t;

  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;
endpackage

module ace_snoop_responder #(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned BeatsPerLine = 4,
  parameter type snoop_req_t  = ace_snoop_pkg::snoop_req_t,
  parameter type snoop_resp_t = ace_snoop_pkg::snoop_resp_t
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  snoop_req_t                      snoop_req_i,
  output snoop_resp_t                     snoop_resp_o,
  output logic                            lkp_valid_o,
  output logic [AddrWidth-1:0]            lkp_addr_o,
  input  logic                            lkp_ready_i,
  input  logic                            lkp_hit_i,
  input  logic                            lkp_dirty_i,
  input  logic                            lkp_shared_i,
  output logic                            rd_en_o,
  output logic [AddrWidth-1:0]            rd_addr_o,
  output logic [$clog2(BeatsPerLine)-1:0] rd_beat_o,
  input  logic [DataWidth-1:0]            rd_data_i,
  output logic                            upd_valid_o,
  output logic [AddrWidth-1:0]            upd_addr_o,
  output logic                            upd_inval_o,
  output logic                            upd_clean_o,
  output logic                            upd_shared_o,
  input  logic                            upd_ready_i
);
  localparam int unsigned BeatW = $clog2(BeatsPerLine);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, SEND_CR, RD_BEAT, DRIVE_BEAT, UPDATE
  } state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [3:0]           snoop_q, snoop_d;
  logic [4:0]           resp_q, resp_d;
  logic                 need_data_q, need_data_d;
  logic                 need_upd_q, need_upd_d;
  logic                 inval_q, inval_d;
  logic                 clean_q, clean_d;
  logic                 shared_q, shared_d;
  logic [BeatW-1:0]     beat_q, beat_d;
  logic [DataWidth-1:0] hold_q, hold_d;
  logic                 fresh_q, fresh_d;

  logic dec_known, dec_data, dec_is_shared, dec_pass_dirty;
  logic dec_inval, dec_clean, dec_shared, dec_valid;
  logic last_beat;

  // Snoop decode of the latched opcode against the current lookup result.
  always_comb begin
    dec_known      = 1'b1;
    dec_data       = 1'b0;
    dec_is_shared  = 1'b0;
    dec_pass_dirty = 1'b0;
    dec_inval      = 1'b0;
    dec_clean      = 1'b0;
    dec_shared     = 1'b0;
    case (snoop_q)
      4'b0000: begin
        dec_data      = 1'b1;
        dec_is_shared = 1'b1;
      end
      4'b0001, 4'b0010, 4'b0011: begin
        dec_data       = 1'b1;
        dec_is_shared  = 1'b1;
        dec_pass_dirty = lkp_dirty_i;
        dec_clean      = 1'b1;
        dec_shared     = 1'b1;
      end
      4'b0111, 4'b1001: begin
        dec_data       = 1'b1;
        dec_pass_dirty = lkp_dirty_i;
        dec_inval      = 1'b1;
      end
      4'b1101: dec_inval = 1'b1;
      4'b1000: begin
        dec_is_shared = 1'b1;
        if (lkp_dirty_i) begin
          dec_data       = 1'b1;
          dec_pass_dirty = 1'b1;
          dec_clean      = 1'b1;
        end
      end
      default: dec_known = 1'b0;
    endcase
    dec_valid = lkp_hit_i & dec_known;
  end

  assign last_beat = (beat_q == BeatW'(BeatsPerLine - 1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    snoop_d     = snoop_q;
    resp_d      = resp_q;
    need_data_d = need_data_q;
    need_upd_d  = need_upd_q;
    inval_d     = inval_q;
    clean_d     = clean_q;
    shared_d    = shared_q;
    beat_d      = beat_q;
    hold_d      = hold_q;
    fresh_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (snoop_req_i.ac_valid) begin
          addr_d  = snoop_req_i.ac.addr;
          snoop_d = snoop_req_i.ac.snoop;
          beat_d  = '0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lkp_ready_i) begin
          resp_d      = dec_valid ? {~lkp_shared_i, dec_is_shared, dec_pass_dirty, 1'b0, dec_data}
                                  : 5'b0;
          need_data_d = dec_valid & dec_data;
          inval_d     = dec_valid & dec_inval;
          clean_d     = dec_valid & dec_clean;
          shared_d    = dec_valid & dec_shared;
          need_upd_d  = dec_valid & (dec_inval | dec_clean | dec_shared);
          state_d     = SEND_CR;
        end
      end
      SEND_CR: begin
        if (snoop_req_i.cr_ready) begin
          if (need_data_q)     state_d = RD_BEAT;
          else if (need_upd_q) state_d = UPDATE;
          else                 state_d = IDLE;
        end
      end
      RD_BEAT: begin
        state_d = DRIVE_BEAT;
        fresh_d = 1'b1;
      end
      // RAM data arrives in the first DRIVE_BEAT cycle; it is captured then so
      // the beat stays stable however long the CCU stalls.
      DRIVE_BEAT: begin
        if (fresh_q) hold_d = rd_data_i;
        if (snoop_req_i.cd_ready) begin
          if (last_beat) begin
            state_d = need_upd_q ? UPDATE : IDLE;
          end else begin
            beat_d  = beat_q + BeatW'(1);
            state_d = RD_BEAT;
          end
        end
      end
      UPDATE: begin
        if (upd_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      snoop_q     <= '0;
      resp_q      <= '0;
      need_data_q <= 1'b0;
      need_upd_q  <= 1'b0;
      inval_q     <= 1'b0;
      clean_q     <= 1'b0;
      shared_q    <= 1'b0;
      beat_q      <= '0;
      hold_q      <= '0;
      fresh_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      snoop_q     <= snoop_d;
      resp_q      <= resp_d;
      need_data_q <= need_data_d;
      need_upd_q  <= need_upd_d;
      inval_q     <= inval_d;
      clean_q     <= clean_d;
      shared_q    <= shared_d;
      beat_q      <= beat_d;
      hold_q      <= hold_d;
      fresh_q     <= fresh_d;
    end
  end

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = (state_q == IDLE);
    snoop_resp_o.cr_valid = (state_q == SEND_CR);
    snoop_resp_o.cr_resp  = resp_q;
    snoop_resp_o.cd_valid = (state_q == DRIVE_BEAT);
    snoop_resp_o.cd.data  = (state_q == DRIVE_BEAT) ? (fresh_q ? rd_data_i : hold_q) : '0;
    snoop_resp_o.cd.last  = (state_q == DRIVE_BEAT) && last_beat;
  end

  assign lkp_valid_o  = (state_q == LOOKUP);
  assign lkp_addr_o   = addr_q;
  assign rd_en_o      = (state_q == RD_BEAT);
  assign rd_addr_o    = addr_q;
  assign rd_beat_o    = beat_q;
  assign upd_valid_o  = (state_q == UPDATE);
  assign upd_addr_o   = addr_q;
  assign upd_inval_o  = inval_q;
  assign upd_clean_o  = clean_q;
  assign upd_shared_o = shared_q;
endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: directed test-plan snoops
// followed by randomized snoops scored against a rule-level reference model.
module tb_ace_snoop_responder;
  import ace_snoop_pkg::*;

  localparam int BPL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  snoop_req_t  req;
  snoop_resp_t resp;
  logic        lkp_valid, lkp_ready, lkp_hit, lkp_dirty, lkp_shared;
  logic [31:0] lkp_addr, rd_addr, upd_addr;
  logic        rd_en;
  logic [1:0]  rd_beat;
  logic [63:0] rd_data;
  logic        upd_valid, upd_inval, upd_clean, upd_shared, upd_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ace_snoop_responder #(
    .AddrWidth(32), .DataWidth(64), .BeatsPerLine(BPL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .snoop_req_i(req), .snoop_resp_o(resp),
    .lkp_valid_o(lkp_valid), .lkp_addr_o(lkp_addr), .lkp_ready_i(lkp_ready),
    .lkp_hit_i(lkp_hit), .lkp_dirty_i(lkp_dirty), .lkp_shared_i(lkp_shared),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_beat_o(rd_beat), .rd_data_i(rd_data),
    .upd_valid_o(upd_valid), .upd_addr_o(upd_addr), .upd_inval_o(upd_inval),
    .upd_clean_o(upd_clean), .upd_shared_o(upd_shared), .upd_ready_i(upd_ready)
  );

  function automatic logic [63:0] ram_word(input logic [31:0] a, input logic [1:0] b);
    return {a, 24'hC0FFEE, 6'd0, b};
  endfunction

  // Data RAM: valid word one cycle after a read strobe, junk otherwise.
  always @(posedge clk) rd_data <= rd_en ? ram_word(rd_addr, rd_beat) : {$urandom, $urandom};

  typedef struct {
    logic [4:0] resp;
    int         beats;
    bit         upd;
    bit         inval;
    bit         clean;
    bit         shared;
  } exp_t;

  // Reference: what the snoop rules say the CCU should see for one snoop.
  function automatic exp_t model(input logic [3:0] code, input bit hit, input bit dirty,
                                 input bit shr);
    exp_t e;
    bit data = 0, is_sh = 0, pd = 0, known = 1;
    e = '{resp: 5'b0, beats: 0, upd: 0, inval: 0, clean: 0, shared: 0};
    case (code)
      4'b0000: begin data = 1; is_sh = 1; end
      4'b0001, 4'b0010, 4'b0011: begin
        data = 1; is_sh = 1; pd = dirty; e.clean = 1; e.shared = 1;
      end
      4'b0111, 4'b1001: begin data = 1; pd = dirty; e.inval = 1; end
      4'b1101: e.inval = 1;
      4'b1000: begin
        is_sh = 1;
        if (dirty) begin data = 1; pd = 1; e.clean = 1; end
      end
      default: known = 0;
    endcase
    if (!hit || !known) return '{resp: 5'b0, beats: 0, upd: 0, inval: 0, clean: 0, shared: 0};
    e.resp  = {!shr, is_sh, pd, 1'b0, data};
    e.beats = data ? BPL : 0;
    e.upd   = e.inval | e.clean | e.shared;
    return e;
  endfunction

  function automatic logic rnd(input int pct);
    return ($urandom_range(99) >= pct);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string pfx);
    checkOutput({pfx, "_ac_ready"}, 64'(resp.ac_ready), 64'd1);
    checkOutput({pfx, "_cr_valid"}, 64'(resp.cr_valid), 64'd0);
    checkOutput({pfx, "_cd_valid"}, 64'(resp.cd_valid), 64'd0);
    checkOutput({pfx, "_lkp_valid"}, 64'(lkp_valid), 64'd0);
    checkOutput({pfx, "_upd_valid"}, 64'(upd_valid), 64'd0);
    checkOutput({pfx, "_rd_en"}, 64'(rd_en), 64'd0);
    checkOutput({pfx, "_cd_data"}, resp.cd.data, 64'd0);
  endtask

  // Runs one snoop from AC handshake back to IDLE and scores everything seen.
  task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [3:0] code,
                               input bit hit, input bit dirty, input bit shr, input int stall_pct,
                               input int hold_beat, input int hold_cycles, input bit pend_ac,
                               input bit abort, input bit chk_lat);
    exp_t        e;
    int          cyc, lkp_cyc, cr_cyc, rd_cyc, cd_cyc, done_cyc, held, rd_cnt, upd_cnt;
    logic [4:0]  got_resp;
    bit          got_cr, order_bad, stab_bad, addr_bad, prev_cd_stall, prev_cr_stall, upd_seen;
    logic [64:0] prev_cd;
    logic [4:0]  prev_cr;
    logic [63:0] beat_data[$];
    bit          beat_last[$];
    logic [31:0] got_upd_addr;
    bit          gi, gc, gs;

    e = model(code, hit, dirty, shr);
    lkp_cyc = -1; cr_cyc = -1; rd_cyc = -1; cd_cyc = -1; done_cyc = -1;
    held = 0; rd_cnt = 0; upd_cnt = 0; got_resp = 'x; got_cr = 0;
    order_bad = 0; stab_bad = 0; addr_bad = 0; prev_cd_stall = 0; prev_cr_stall = 0;
    prev_cd = '0; prev_cr = '0; got_upd_addr = '0; gi = 0; gc = 0; gs = 0;

    req.ac.addr  = addr;
    req.ac.snoop = code;
    req.ac_valid = 1'b1;
    lkp_hit = hit; lkp_dirty = dirty; lkp_shared = shr;
    checkOutput({name, "_ac_ready_start"}, 64'(resp.ac_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req.ac_valid = 1'b0;
    cyc = 1;
    while (cyc < 300) begin
      if (resp.ac_ready) begin
        done_cyc = cyc;
        break;
      end
      if (lkp_valid && lkp_cyc < 0) lkp_cyc = cyc;
      if (lkp_valid && lkp_addr !== addr) addr_bad = 1;
      if (resp.cr_valid && cr_cyc < 0) cr_cyc = cyc;
      if (resp.cd_valid && cd_cyc < 0) cd_cyc = cyc;
      if (rd_en) begin
        rd_cnt++;
        if (rd_cyc < 0) rd_cyc = cyc;
        if (rd_addr !== addr || int'(rd_beat) != beat_data.size() || !got_cr) order_bad = 1;
      end
      if (resp.cd_valid && !got_cr) order_bad = 1;
      if (upd_valid && beat_data.size() != e.beats) order_bad = 1;
      if (prev_cd_stall && (!resp.cd_valid || {resp.cd.data, resp.cd.last} !== prev_cd))
        stab_bad = 1;
      if (prev_cr_stall && (!resp.cr_valid || resp.cr_resp !== prev_cr)) stab_bad = 1;

      if (abort && resp.cd_valid) begin
        rst_n = 1'b0;
        #1;
        checkIdleOutputs({name, "_in_reset"});
        @(negedge clk);
        rst_n = 1'b1;
        upd_seen = 0;
        repeat (6) begin
          @(negedge clk);
          if (upd_valid) upd_seen = 1;
        end
        checkOutput({name, "_no_upd_after_abort"}, 64'(upd_seen), 64'd0);
        checkIdleOutputs({name, "_after_abort"});
        return;
      end
      if (pend_ac && resp.cd_valid) req.ac_valid = 1'b1;

      lkp_ready    = rnd(stall_pct);
      req.cr_ready = rnd(stall_pct);
      upd_ready    = rnd(stall_pct);
      if (resp.cd_valid && beat_data.size() == hold_beat && held < hold_cycles) begin
        req.cd_ready = 1'b0;
        held++;
      end else begin
        req.cd_ready = rnd(stall_pct);
      end

      if (resp.cr_valid && req.cr_ready) begin
        got_cr = 1;
        got_resp = resp.cr_resp;
      end
      prev_cr_stall = resp.cr_valid && !req.cr_ready;
      prev_cr = resp.cr_resp;
      prev_cd_stall = resp.cd_valid && !req.cd_ready;
      prev_cd = {resp.cd.data, resp.cd.last};
      if (resp.cd_valid && req.cd_ready) begin
        beat_data.push_back(resp.cd.data);
        beat_last.push_back(resp.cd.last);
      end
      if (upd_valid && upd_ready) begin
        upd_cnt++;
        got_upd_addr = upd_addr; gi = upd_inval; gc = upd_clean; gs = upd_shared;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end

    checkOutput({name, "_done_in_bound"}, 64'(done_cyc >= 0), 64'd1);
    checkOutput({name, "_cr_seen"}, 64'(got_cr), 64'd1);
    checkOutput({name, "_cr_resp"}, 64'(got_resp), 64'(e.resp));
    checkOutput({name, "_beats"}, 64'(beat_data.size()), 64'(e.beats));
    for (int i = 0; i < beat_data.size() && i < e.beats; i++) begin
      checkOutput($sformatf("%s_beat%0d_data", name, i), beat_data[i], ram_word(addr, 2'(i)));
      checkOutput($sformatf("%s_beat%0d_last", name, i), 64'(beat_last[i]), 64'(i == BPL - 1));
    end
    checkOutput({name, "_rd_count"}, 64'(rd_cnt), 64'(e.beats));
    checkOutput({name, "_upd_count"}, 64'(upd_cnt), 64'(e.upd));
    if (e.upd && upd_cnt == 1) begin
      checkOutput({name, "_upd_addr"}, 64'(got_upd_addr), 64'(addr));
      checkOutput({name, "_upd_flags"}, 64'({gi, gc, gs}), 64'({e.inval, e.clean, e.shared}));
    end
    checkOutput({name, "_ordering"}, 64'(order_bad), 64'd0);
    checkOutput({name, "_stability"}, 64'(stab_bad), 64'd0);
    checkOutput({name, "_lkp_addr"}, 64'(addr_bad), 64'd0);
    if (chk_lat) begin
      checkOutput({name, "_lat_lkp"}, 64'(lkp_cyc), 64'd1);
      checkOutput({name, "_lat_cr"}, 64'(cr_cyc), 64'd2);
      checkOutput({name, "_lat_rd"}, 64'(rd_cyc), (e.beats > 0) ? 64'd3 : 64'(-1));
      checkOutput({name, "_lat_cd"}, 64'(cd_cyc), (e.beats > 0) ? 64'd4 : 64'(-1));
      checkOutput({name, "_lat_done"}, 64'(done_cyc), 64'(3 + 2 * e.beats + int'(e.upd)));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the bench finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] code;
    rst_n = 1'b0;
    req = '0;
    lkp_ready = 0; lkp_hit = 0; lkp_dirty = 0; lkp_shared = 0; upd_ready = 0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    checkIdleOutputs("reset_idle");

    $display("[TB] directed snoops");
    applyStimulus("read_unique", 32'h1000, 4'b0111, 1, 1, 0, 0, -1, 0, 0, 0, 1);
    applyStimulus("read_shared", 32'h2040, 4'b0001, 1, 0, 1, 0, -1, 0, 0, 0, 1);
    applyStimulus("make_inval_u", 32'h3000, 4'b1101, 1, 0, 0, 0, -1, 0, 0, 0, 1);
    applyStimulus("make_inval_s", 32'h3040, 4'b1101, 1, 1, 1, 0, -1, 0, 0, 0, 1);
    applyStimulus("make_inval_miss", 32'h3080, 4'b1101, 0, 1, 0, 0, -1, 0, 0, 0, 1);
    applyStimulus("clean_shared_d", 32'h4000, 4'b1000, 1, 1, 0, 0, 1, 3, 0, 0, 0);
    applyStimulus("clean_shared_c", 32'h4040, 4'b1000, 1, 0, 1, 0, -1, 0, 0, 0, 1);
    applyStimulus("read_once", 32'h5000, 4'b0000, 1, 1, 0, 0, -1, 0, 0, 0, 1);
    applyStimulus("unknown_code", 32'h5040, 4'b0100, 1, 1, 0, 0, -1, 0, 0, 0, 1);
    applyStimulus("busy_first", 32'h6000, 4'b1001, 1, 0, 0, 0, -1, 0, 1, 0, 1);
    applyStimulus("busy_second", 32'h6000, 4'b1001, 1, 0, 0, 0, -1, 0, 0, 0, 1);
    applyStimulus("abort", 32'h7000, 4'b0111, 1, 1, 0, 0, -1, 0, 0, 1, 0);

    $display("[TB] randomized snoops");
    for (int i = 0; i < 40; i++) begin
      code = 4'($urandom_range(15));
      applyStimulus($sformatf("rand%0d", i), {20'($urandom), 12'h0} | 32'(i << 6), code,
                    1'($urandom), 1'($urandom), 1'($urandom), 30, -1, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ace_snoop_responder.md
# ace_snoop_responder

Snoop-side responder for an ACE master port, the counterpart of the CCU snoop initiator. It accepts one AC snoop request at a time and looks the line up in the local cache tag/state array. It returns a CR response, streams CD data beats from the cache data RAM when required, and commits the resulting state change (invalidate / clean / make-shared) back to the cache.

## Interface
- `AddrWidth`, 32: snoop address width.
- `DataWidth`, 64: CD beat width.
- `BeatsPerLine`, 4: CD beats per cache line; must be a power of two and ≥ 2.
- `snoop_req_t`, logic: codebase snoop request struct (`ac`, `ac_valid`, `cr_ready`, `cd_ready`).
- `snoop_resp_t`, logic: codebase snoop response struct (`ac_ready`, `cr_valid`, `cr_resp[4:0]`, `cd_valid`, `cd.data`, `cd.last`).
- `clk_i` in 1: clock; single clock domain.
- `rst_ni` in 1: asynchronous, active-low reset.
- `snoop_req_i` in snoop_req_t: AC request, plus CR/CD ready from the CCU.
- `snoop_resp_o` out snoop_resp_t: AC ready, CR response, CD data toward the CCU.
- `lkp_valid_o` out 1: tag lookup request.
- `lkp_addr_o` out AddrWidth: lookup address, which is the latched `ac.addr`.
- `lkp_ready_i` in 1: lookup accepted. `lkp_hit_i`, `lkp_dirty_i` and `lkp_shared_i` are valid in the same cycle.
- `lkp_hit_i`, `lkp_dirty_i`, `lkp_shared_i` in 1 each: line state.
- `rd_en_o` out 1: data RAM read strobe.
- `rd_addr_o` out AddrWidth: latched address.
- `rd_beat_o` out $clog2(BeatsPerLine): beat index.
- `rd_data_i` in DataWidth: read data, valid the cycle after `rd_en_o`.
- `upd_valid_o` out 1: state update request.
- `upd_addr_o` out AddrWidth: latched address.
- `upd_inval_o`, `upd_clean_o`, `upd_shared_o` out 1 each: update actions.
- `upd_ready_i` in 1: update accepted.

## Operation
- **Snoop decode.** Each rule applies only on a hit. A miss always gives resp=0, no data and no update.
  - ReadOnce 0000: data; IsShared=1; no update.
  - ReadShared 0001, ReadClean 0010, ReadNotSharedDirty 0011:
    - data; IsShared=1; PassDirty=dirty;
    - update clean=1, shared=1.
  - ReadUnique 0111, CleanInvalid 1001: data; PassDirty=dirty; update inval=1.
  - MakeInvalid 1101: no data; update inval=1.
  - CleanShared 1000:
    - if dirty: data; PassDirty=1; IsShared=1; update clean=1;
    - if clean: IsShared=1; no data; no update.
  - Any other code: resp=0, no data, no update (Error bit never set).
- **CR response bits.**
  - `cr_resp` = {WasUnique, IsShared, PassDirty, Error=0, DataTransfer}.
  - WasUnique = hit & !shared.
  - DataTransfer = 1 exactly when CD beats follow.
- **FSM states.**
  - IDLE: `ac_ready`=1. On `ac_valid`, latch `ac` and go to LOOKUP.
  - LOOKUP: `lkp_valid_o`=1. On `lkp_ready_i`, register the response and flags, then go to SEND_CR.
  - SEND_CR: `cr_valid`=1, `cr_resp` stable. On `cr_ready`:
    - go to RD_BEAT if data is required;
    - else go to UPDATE if an update is required;
    - else go to IDLE.
  - RD_BEAT: `rd_en_o`=1 with `rd_beat_o`=beat counter; go to DRIVE_BEAT.
  - DRIVE_BEAT: latch `rd_data_i` into the holding register on entry and drive `cd_valid`=1 from it. `cd.last` = (counter == BeatsPerLine−1). On `cd_ready`:
    - if last, go to UPDATE or IDLE;
    - else increment the counter and go to RD_BEAT.
  - UPDATE: `upd_valid_o`=1 with the flags. On `upd_ready_i`, go to IDLE.
- **Beat counter.** Reset to 0 on AC acceptance. It never wraps within a line.
- **Ordering.**
  - At most one snoop is outstanding.
  - CR always completes before the first CD beat.
  - The update is issued only after the last CD handshake, so the line is never invalidated before its data has left.

## Timing
- **Reset values.** State=IDLE, so `ac_ready`=1. All other outputs, registers and the counter are 0. Reset asserted mid-transaction aborts to IDLE immediately; no partial update is issued.
- **Output stability.** `cr_valid`, `cd_valid`, `lkp_valid_o` and `upd_valid_o` are held with stable payload until their handshake and do not depend combinationally on the matching ready.
- **Latency, AC handshake at cycle 0 with zero-wait lookup.**
  - `lkp_valid_o` in cycle 1.
  - `cr_valid` in cycle 2.
  - With `cr_ready`=1 in cycle 2: `rd_en_o` in cycle 3, first `cd_valid` in cycle 4.
  - Each further beat costs 2 cycles, so the minimum snoop with data and update is 2+1+2·BeatsPerLine+1 cycles.
- **Back-pressure.** `ac_ready` is 0 in every non-IDLE state. A new `ac_valid` arriving while busy waits.

## Test plan
- Reset then idle → `ac_ready`=1; `cr_valid`, `cd_valid`, `lkp_valid_o`, `upd_valid_o`, `rd_en_o` all 0.
- ReadUnique to 0x1000, hit dirty unique, all readies 1 (BeatsPerLine=4):
  - `cr_resp`=5'b10101 in cycle 2;
  - 4 CD beats with RAM data beats 0–3, `cd.last` on beat 3;
  - then one `upd_valid_o` cycle with inval=1, addr 0x1000.
- ReadShared, hit clean shared → `cr_resp`=5'b01001, 4 beats, update clean=1 shared=1.
- MakeInvalid, hit → `cr_resp`=5'b10000 (or 5'b00000 if shared), no `rd_en_o`, update inval=1. Same snoop on a miss → resp 0, no update, back to IDLE.
- CleanShared, hit dirty, with `cd_ready` low for 3 cycles on beat 1 → beat 1 data and `cd.last`=0 held stable throughout; update clean=1 only after the beat-3 handshake.
- Second `ac_valid` asserted during DRIVE_BEAT → not accepted until IDLE. `rst_ni` pulsed during DRIVE_BEAT → all outputs return to reset values and no update is issued.
